// File: rtl/rv_prog_loader_if.sv
// Field-bundle handshake and instruction-memory write bus for rv_prog_loader.
//   in_valid/in_ready : bundle handshake (master drives valid and fields)
//   fmt, op, rd, rs1, rs2, funct3, funct7_5, imm : decoded instruction fields
//   mem_we/mem_addr/mem_wdata : instruction-memory write port (slave drives)
interface rv_prog_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_valid, fmt, op, rd, rs1, rs2, funct3, funct7_5, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, fmt, op, rd, rs1, rs2, funct3, funct7_5, imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv_prog_loader.sv
// RV32I instruction-word encoder and sequential program writer.
// Packs a decoded field bundle into a 32-bit word by format and writes it to
// instruction memory at an auto-incrementing word address.
//   clk, rst_n  : clock, asynchronous active-low reset
//   prog_start  : rewinds the write pointer, clears count and full
//   bus         : field handshake + memory write port (slave side)
//   count       : words written since reset / prog_start
//   full        : count == DEPTH, further bundles are blocked
//   err         : one-cycle pulse for a consumed bundle with illegal fmt
module rv_prog_loader #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prog_start,
    rv_prog_loader_if.slave        bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   err
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] enc_word;
    logic        fmt_ok;

    assign bus.in_ready = (state == IDLE) & ~prog_start;

    // Field packing by format; shifts (funct3 001/101) carry funct7_5 and shamt.
    always_comb begin
        enc_word = '0;
        fmt_ok   = 1'b1;
        case (bus.fmt)
            FMT_R: enc_word = {1'b0, bus.funct7_5, 5'b0, bus.rs2, bus.rs1,
                               bus.funct3, bus.rd, bus.op};
            FMT_I: begin
                if (bus.funct3 == 3'b001 || bus.funct3 == 3'b101)
                    enc_word = {1'b0, bus.funct7_5, 5'b0, bus.imm[4:0], bus.rs1,
                                bus.funct3, bus.rd, bus.op};
                else
                    enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.op};
            end
            FMT_S: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:0], bus.op};
            FMT_B: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1,
                               bus.funct3, bus.imm[4:1], bus.imm[11], bus.op};
            FMT_U: enc_word = {bus.imm[31:12], bus.rd, bus.op};
            FMT_J: enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11],
                               bus.imm[19:12], bus.rd, bus.op};
            default: fmt_ok = 1'b0;
        endcase
    end

    // Control FSM with registered memory port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= '0;
            count         <= '0;
            full          <= 1'b0;
            err           <= 1'b0;
        end else if (prog_start) begin
            // An in-flight write already drove mem_we this cycle; only its increment is dropped.
            state        <= IDLE;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= BASE_ADDR;
            count        <= '0;
            full         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (fmt_ok)
                            bus.mem_wdata <= enc_word;
                        bus.mem_we <= fmt_ok;
                        err        <= ~fmt_ok;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    bus.mem_we <= 1'b0;
                    err        <= 1'b0;
                    state      <= IDLE;
                    if (bus.mem_we) begin
                        count        <= count + CNT_W'(1);
                        bus.mem_addr <= bus.mem_addr + 32'd4;
                        if (count == CNT_W'(DEPTH - 1)) begin
                            full  <= 1'b1;
                            state <= FULL;
                        end
                    end
                end
                FULL: state <= FULL;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_prog_loader.sv
// Randomized + directed scoreboard bench for rv_prog_loader (DEPTH=4).
module tb_rv_prog_loader;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic [31:0] imm;
    } bundle_t;

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic prog_start = 1'b0;
    logic [2:0] count;
    logic full, err;

    rv_prog_loader_if bus ();

    rv_prog_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .prog_start(prog_start),
        .bus(bus), .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int model_count = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference encoder built from bit positions with plain arithmetic.
    function automatic logic [31:0] model_enc(input bundle_t b);
        logic [31:0] op, rd, r1, r2, f3, f7, im;
        op = 32'(b.op); rd = 32'(b.rd); r1 = 32'(b.rs1); r2 = 32'(b.rs2);
        f3 = 32'(b.funct3); f7 = 32'(b.funct7_5); im = b.imm;
        case (b.fmt)
            3'd0: return (f7 << 30) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd1: begin
                if (f3 == 1 || f3 == 5)
                    return (f7 << 30) | ((im & 32'h1F) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
                return ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            3'd2: return (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                         | ((im & 32'h1F) << 7) | op;
            3'd3: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
                         | (r1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                         | (((im >> 11) & 1) << 7) | op;
            3'd4: return (im & 32'hFFFF_F000) | (rd << 7) | op;
            3'd5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                         | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: every write or err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.mem_we || err)) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: we=%0b err=%0b addr=0x%08h with empty scoreboard",
                         bus.mem_we, err, bus.mem_addr);
            end else begin
                e = sb.pop_front();
                if (e.is_err) begin
                    if (!(err && !bus.mem_we)) begin
                        bad++;
                        $display("FAIL err_pulse: got err=%0b we=%0b expected err=1 we=0", err, bus.mem_we);
                    end
                end else if (!(bus.mem_we && !err && bus.mem_addr === e.addr && bus.mem_wdata === e.wdata)) begin
                    bad++;
                    $display("FAIL write: got we=%0b err=%0b addr=0x%08h data=0x%08h expected addr=0x%08h data=0x%08h",
                             bus.mem_we, err, bus.mem_addr, bus.mem_wdata, e.addr, e.wdata);
                end
            end
        end
    end

    task automatic drive(input bundle_t b);
        bus.fmt = b.fmt; bus.op = b.op; bus.rd = b.rd; bus.rs1 = b.rs1; bus.rs2 = b.rs2;
        bus.funct3 = b.funct3; bus.funct7_5 = b.funct7_5; bus.imm = b.imm;
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input string nm, input bundle_t b, input logic [31:0] exp_w, input bit chk_gap);
        bit done = 0;
        drive(b);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                chk({nm, "_count"}, 32'(count), 32'(model_count));
                chk({nm, "_addr"}, bus.mem_addr, BASE + 32'(4 * model_count));
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                if (chk_gap) chk({nm, "_gap"}, 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                if (b.fmt <= 3'd5) begin
                    sb.push_back('{is_err: 1'b0, addr: BASE + 32'(4 * model_count), wdata: exp_w});
                    model_count++;
                end else begin
                    sb.push_back('{is_err: 1'b1, addr: 32'h0, wdata: 32'h0});
                end
                done = 1;
            end
        end
        if (!done) begin
            total++; bad++;
            bus.in_valid = 1'b0;
            $display("FAIL %s_timeout: got no accept expected accept within 50 cycles", nm);
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        prog_start = 1'b1;
        @(posedge clk); #1;
        prog_start = 1'b0;
        model_count = 0;
    endtask

    // With the loader full, held in_valid must be ignored.
    task automatic full_check(input bundle_t b);
        drive(b);
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'(DEPTH));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic bundle_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                   input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                                   input logic f7, input logic [31:0] im);
        bundle_t b;
        b.fmt = f; b.op = op; b.rd = rd; b.rs1 = r1; b.rs2 = r2;
        b.funct3 = f3; b.funct7_5 = f7; b.imm = im;
        return b;
    endfunction

    function automatic bundle_t rnd_bundle();
        bundle_t b;
        b.fmt = 3'($urandom_range(0, 7)); b.op = 7'($urandom); b.rd = 5'($urandom);
        b.rs1 = 5'($urandom); b.rs2 = 5'($urandom); b.funct3 = 3'($urandom);
        b.funct7_5 = 1'($urandom); b.imm = $urandom;
        return b;
    endfunction

    initial begin
        bundle_t b;
        bus.in_valid = 1'b0;
        drive(mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0));
        #12;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, BASE);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed encodings, back to back (in_valid effectively held high).
        send("i_basic", mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5), 32'h0050_0093, 0);
        send("r_type", mk(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0), 32'h4020_81B3, 1);
        send("s_type", mk(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8), 32'h0020_A423, 1);
        send("b_type", mk(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC), 32'hFE20_8EE3, 1);
        full_check(mk(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1));
        pulse_start();
        chk("restart_full", 32'(full), 32'd0);
        chk("restart_count", 32'(count), 32'd0);
        chk("restart_addr", bus.mem_addr, BASE);

        send("j_type", mk(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8), 32'h0080_00EF, 0);
        send("u_type", mk(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000), 32'h1234_52B7, 1);
        send("illegal", mk(3'd6, 7'b0010011, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd1), 32'h0, 1);
        b = mk(3'd1, 7'b0010011, 5'd4, 5'd2, 5'd0, 3'b101, 1'b1, 32'd7);
        send("i_shift", b, model_enc(b), 1);

        // prog_start and in_valid together in IDLE: no accept, pointer rewound.
        @(posedge clk); #1;
        prog_start = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("start_vs_valid_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        prog_start = 1'b0;
        bus.in_valid = 1'b0;
        model_count = 0;
        chk("start_vs_valid_we", 32'(bus.mem_we), 32'd0);
        chk("start_vs_valid_count", 32'(count), 32'd0);
        chk("start_vs_valid_addr", bus.mem_addr, BASE);

        // Randomized bundles against the reference encoder.
        for (int n = 0; n < 150; n++) begin
            if (model_count == DEPTH) begin
                full_check(rnd_bundle());
                pulse_start();
            end else if ($urandom_range(0, 15) == 0) begin
                pulse_start();
            end
            b = rnd_bundle();
            send("rand", b, model_enc(b), 0);
        end
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a write.
        if (model_count == DEPTH) pulse_start();
        drive(mk(3'd4, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000));
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("midwrite_we_before", 32'(bus.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midwrite_we_after", 32'(bus.mem_we), 32'd0);
        chk("midwrite_addr", bus.mem_addr, BASE);
        chk("midwrite_wdata", bus.mem_wdata, 32'd0);
        chk("midwrite_count", 32'(count), 32'd0);
        chk("midwrite_full", 32'(full), 32'd0);
        chk("midwrite_err", 32'(err), 32'd0);
        chk("midwrite_ready", 32'(bus.in_ready), 32'd1);
        model_count = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
